// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared constants and types for the fetch/decode pipeline-register block.
//   RESET_PC    : fetch address loaded on reset.
//   NOP_INSTR   : MOV r0,r0, the instruction word of a bubble.
//   PC_STEP     : sequential fetch increment.
//   PC_R15_OFS  : ARM R15 read offset (PC of instruction + 8).
//   boot_state_t: boot FSM encoding {BOOT, RUN}.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR  = 32'hE1A0_0000;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] PC_R15_OFS = 32'd8;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } boot_state_t;

endpackage

// File: rtl/pipe_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg
//   Generic pipeline register with synchronous reset, clear and enable.
//   Priority: rst -> RST_VAL, clr_i -> CLR_VAL, en_i -> d_i, else hold.
//   Ports:
//     clk   : clock (rising edge)
//     rst   : synchronous active-high reset
//     en_i  : load d_i when high, hold when low
//     clr_i : load CLR_VAL (wins over en_i)
//     d_i   : next value
//     q_o   : registered value
// -----------------------------------------------------------------------------
module pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else if (clr_i) begin
      q_q <= CLR_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_decode_pipe.sv
// -----------------------------------------------------------------------------
// fetch_decode_pipe
//   Owns the PC, the Fetch->Decode register and the Execute valid bit of the
//   ARM-style pipeline. Obeys the hazard unit's StallF/StallD/FlushD/FlushE
//   and downstream redirects (taken branch / PC write).
//
//   Control semantics (level-sensitive, sampled on the rising edge):
//     StallF/StallD hold their register; FlushD/FlushE load a bubble;
//     RedirectE with RedirectPC steers fetch and squashes Decode and Execute.
//
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     StallF, StallD    : hold PCF / hold Fetch->Decode register
//     FlushD, FlushE    : bubble into Decode / Execute
//     RedirectE         : redirect fetch to RedirectPC (word aligned)
//     InstrF            : instruction memory data for PCF
//     PCF               : fetch address
//     InstrD, PCPlus8D  : Decode instruction and its PC+8 (R15 value)
//     ValidD, ValidE    : Decode / Execute hold a real instruction
//     StallCnt,FlushCnt : perf counters (tied to 0 unless PIPE_PERF_CNT_EN)
//
//   Build option: define PIPE_PERF_CNT_EN to instantiate the saturating
//   stall/redirect counters.
//
//   The boot FSM state is held in state_q for observation by checkers.
// -----------------------------------------------------------------------------
module fetch_decode_pipe
  import pipe_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   StallF,
  input  logic                   StallD,
  input  logic                   FlushD,
  input  logic                   FlushE,
  input  logic                   RedirectE,
  input  logic [PC_WIDTH-1:0]    RedirectPC,
  input  logic [INSTR_WIDTH-1:0] InstrF,
  output logic [PC_WIDTH-1:0]    PCF,
  output logic [INSTR_WIDTH-1:0] InstrD,
  output logic [PC_WIDTH-1:0]    PCPlus8D,
  output logic                   ValidD,
  output logic                   ValidE,
  output logic [31:0]            StallCnt,
  output logic [31:0]            FlushCnt
);

  localparam int FD_W = 1 + PC_WIDTH + INSTR_WIDTH;

  localparam logic [PC_WIDTH-1:0]    PC_RST    = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0]    PC_INC    = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0]    PC_R15    = PC_WIDTH'(PC_R15_OFS);
  localparam logic [PC_WIDTH-1:0]    PC_ALIGN  = ~PC_WIDTH'(3);
  localparam logic [INSTR_WIDTH-1:0] NOP_W     = INSTR_WIDTH'(NOP_INSTR);
  // Bubble: {valid=0, pcplus8=0, instr=NOP}
  localparam logic [FD_W-1:0]        FD_BUBBLE = {1'b0, {PC_WIDTH{1'b0}}, NOP_W};

  // ---------------------------------------------------------------------------
  // Boot FSM: one BOOT cycle after reset during which ValidD is masked.
  // ---------------------------------------------------------------------------
  boot_state_t state_q, state_d;
  logic        boot_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    boot_mask = 1'b0;
    case (state_q)
      BOOT: begin
        boot_mask = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC register. Redirect beats StallF; redirect targets are forced to word
  // alignment. Sequential PCs stay aligned because PC_STEP is a multiple of 4.
  // ---------------------------------------------------------------------------
  logic [PC_WIDTH-1:0] pc_d;
  logic                pc_en;

  always_comb begin
    pc_d  = PCF + PC_INC;
    pc_en = ~StallF;
    if (RedirectE) begin
      pc_d  = RedirectPC & PC_ALIGN;
      pc_en = 1'b1;
    end
  end

  pipe_reg #(
    .W       (PC_WIDTH),
    .RST_VAL (PC_RST),
    .CLR_VAL (PC_RST)
  ) u_pc_reg (
    .clk   (clk),
    .rst   (rst),
    .en_i  (pc_en),
    .clr_i (1'b0),
    .d_i   (pc_d),
    .q_o   (PCF)
  );

  // ---------------------------------------------------------------------------
  // Fetch->Decode register. StallD beats FlushD so a load-use stall (which
  // asserts both) keeps the stalled instruction; a redirect beats everything.
  // ---------------------------------------------------------------------------
  logic [FD_W-1:0] fd_d, fd_q;
  logic            fd_en, fd_clr;
  logic            fd_valid;

  always_comb begin
    fd_d   = {1'b1, PCF + PC_R15, InstrF};
    fd_en  = ~StallD;
    fd_clr = RedirectE | (FlushD & ~StallD);
  end

  pipe_reg #(
    .W       (FD_W),
    .RST_VAL (FD_BUBBLE),
    .CLR_VAL (FD_BUBBLE)
  ) u_fd_reg (
    .clk   (clk),
    .rst   (rst),
    .en_i  (fd_en),
    .clr_i (fd_clr),
    .d_i   (fd_d),
    .q_o   (fd_q)
  );

  assign {fd_valid, PCPlus8D, InstrD} = fd_q;
  assign ValidD = fd_valid & ~boot_mask;

  // ---------------------------------------------------------------------------
  // Execute valid bit. Execute never stalls, so it follows ValidD each cycle.
  // ---------------------------------------------------------------------------
  logic valid_e_q, valid_e_d;

  always_comb begin
    valid_e_d = ValidD;
    if (FlushE || RedirectE) begin
      valid_e_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_e_q <= 1'b0;
    end else begin
      valid_e_q <= valid_e_d;
    end
  end

  assign ValidE = valid_e_q;

  // ---------------------------------------------------------------------------
  // Performance counters (saturating).
  // ---------------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (RedirectE && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = 32'd0;
  assign FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode_pipe
//   Directed, table-driven bench for fetch_decode_pipe. Each record holds the
//   inputs for one clock and the outputs expected just after that edge.
//   Counter expectations follow a small model that tracks StallD/RedirectE.
// -----------------------------------------------------------------------------
module tb_fetch_decode_pipe;

  localparam logic [31:0] NOP = 32'hE1A0_0000;
  localparam logic [31:0] IA  = 32'hE080_0001;
  localparam logic [31:0] IB  = 32'hE281_1001;
  localparam logic [31:0] IC  = 32'hE3A0_2005;
  localparam logic [31:0] ID  = 32'hE593_1000;
  localparam logic [31:0] IE  = 32'hE1A0_3004;
  localparam logic [31:0] IF  = 32'hE1A0_1002;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, FlushE = 1'b0;
  logic        RedirectE = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic [31:0] InstrF = '0;
  logic [31:0] PCF, InstrD, PCPlus8D, StallCnt, FlushCnt;
  logic        ValidD, ValidE;

  always #5 clk = ~clk;

  fetch_decode_pipe #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .RedirectE  (RedirectE),
    .RedirectPC (RedirectPC),
    .InstrF     (InstrF),
    .PCF        (PCF),
    .InstrD     (InstrD),
    .PCPlus8D   (PCPlus8D),
    .ValidD     (ValidD),
    .ValidE     (ValidE),
    .StallCnt   (StallCnt),
    .FlushCnt   (FlushCnt)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_stall = '0;
  logic [31:0] exp_flush = '0;

  typedef struct {
    logic        rst, sf, sd, fd, fe, re;
    logic [31:0] rpc, instr;
    logic [31:0] e_pc, e_instr, e_p8;
    logic        e_vd, e_ve;
  } vec_t;

  function automatic vec_t mk(input logic r, sf, sd, fd, fe, re,
                              input logic [31:0] rpc, instr,
                              input logic [31:0] e_pc, e_instr, e_p8,
                              input logic e_vd, e_ve);
    vec_t v;
    v.rst = r; v.sf = sf; v.sd = sd; v.fd = fd; v.fe = fe; v.re = re;
    v.rpc = rpc; v.instr = instr;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_p8 = e_p8;
    v.e_vd = e_vd; v.e_ve = e_ve;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply one record across a clock edge and check after the edge.
  // ---------------------------------------------------------------------------
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; StallF = v.sf; StallD = v.sd; FlushD = v.fd; FlushE = v.fe;
    RedirectE = v.re; RedirectPC = v.rpc; InstrF = v.instr;
`ifdef PIPE_PERF_CNT_EN
    if (v.rst) begin
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      if (v.sd) exp_stall = exp_stall + 32'd1;
      if (v.re) exp_flush = exp_flush + 32'd1;
    end
`endif
    @(posedge clk);
    #1;
    chk("PCF",      idx, PCF,      v.e_pc);
    chk("InstrD",   idx, InstrD,   v.e_instr);
    chk("PCPlus8D", idx, PCPlus8D, v.e_p8);
    chk("ValidD",   idx, {31'd0, ValidD}, {31'd0, v.e_vd});
    chk("ValidE",   idx, {31'd0, ValidE}, {31'd0, v.e_ve});
    chk("StallCnt", idx, StallCnt, exp_stall);
    chk("FlushCnt", idx, FlushCnt, exp_flush);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  vec_t vt[24];

  initial begin
    //            rst sf sd fd fe re  rpc            instr  | pc            instr p8            vd ve
    vt[0]  = mk(1, 0, 0, 0, 0, 0, 32'h0,         IA,   32'h0,         NOP, 32'h0,        0, 0);
    vt[1]  = mk(0, 0, 0, 0, 0, 0, 32'h0,         IA,   32'h4,         IA,  32'h8,        1, 0);
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 32'h0,         IA,   32'h8,         IA,  32'hC,        1, 1);
    vt[3]  = mk(0, 0, 0, 0, 0, 0, 32'h0,         IB,   32'hC,         IB,  32'h10,       1, 1);
    vt[4]  = mk(0, 0, 0, 0, 0, 0, 32'h0,         IC,   32'h10,        IC,  32'h14,       1, 1);
    // load-use stall at PCF=0x10
    vt[5]  = mk(0, 1, 1, 1, 1, 0, 32'h0,         ID,   32'h10,        IC,  32'h14,       1, 0);
    vt[6]  = mk(0, 0, 0, 0, 0, 0, 32'h0,         ID,   32'h14,        ID,  32'h18,       1, 1);
    // redirect while StallF=1
    vt[7]  = mk(0, 1, 0, 0, 0, 1, 32'h200,       IE,   32'h200,       NOP, 32'h0,        0, 0);
    vt[8]  = mk(0, 0, 0, 0, 0, 0, 32'h0,         IF,   32'h204,       IF,  32'h208,      1, 0);
    // misaligned target, then wrap
    vt[9]  = mk(0, 0, 0, 0, 0, 1, 32'h203,       IA,   32'h200,       NOP, 32'h0,        0, 0);
    vt[10] = mk(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, IA,   32'hFFFF_FFFC, NOP, 32'h0,        0, 0);
    vt[11] = mk(0, 0, 0, 0, 0, 0, 32'h0,         IA,   32'h0,         IA,  32'h4,        1, 0);
    vt[12] = mk(0, 0, 0, 0, 0, 0, 32'h0,         IB,   32'h4,         IB,  32'h8,        1, 1);
    // FlushD alone
    vt[13] = mk(0, 0, 0, 1, 0, 0, 32'h0,         IC,   32'h8,         NOP, 32'h0,        0, 1);
    vt[14] = mk(0, 0, 0, 0, 0, 0, 32'h0,         ID,   32'hC,         ID,  32'h10,       1, 0);
    // stall, then reset in the third stall cycle
    vt[15] = mk(0, 1, 1, 1, 1, 0, 32'h0,         IE,   32'hC,         ID,  32'h10,       1, 0);
    vt[16] = mk(0, 1, 1, 1, 1, 0, 32'h0,         IE,   32'hC,         ID,  32'h10,       1, 0);
    vt[17] = mk(1, 1, 1, 1, 1, 0, 32'h0,         IE,   32'h0,         NOP, 32'h0,        0, 0);
    vt[18] = mk(0, 0, 0, 0, 0, 0, 32'h0,         IA,   32'h4,         IA,  32'h8,        1, 0);
    // redirect beats StallD
    vt[19] = mk(0, 0, 1, 0, 0, 1, 32'h40,        IB,   32'h40,        NOP, 32'h0,        0, 0);
    // StallD alone holds the bubble while fetch advances
    vt[20] = mk(0, 0, 1, 0, 0, 0, 32'h0,         IB,   32'h44,        NOP, 32'h0,        0, 0);
    vt[21] = mk(0, 0, 0, 0, 0, 0, 32'h0,         IC,   32'h48,        IC,  32'h4C,       1, 0);
    // StallF alone
    vt[22] = mk(0, 1, 0, 0, 0, 0, 32'h0,         ID,   32'h48,        ID,  32'h50,       1, 1);
    // FlushE alone
    vt[23] = mk(0, 0, 0, 0, 1, 0, 32'h0,         IA,   32'h4C,        IA,  32'h50,       1, 0);

    for (int i = 0; i < 24; i++) begin
      apply(vt[i], i);
    end

    // Hand sequence: reset during redirect, then first fetch after reset.
    apply(mk(1, 0, 0, 0, 0, 1, 32'h300, IB, 32'h0, NOP, 32'h0, 0, 0), 100);
    apply(mk(0, 0, 0, 0, 0, 0, 32'h0,   IB, 32'h4, IB,  32'h8, 1, 0), 101);
    // Redirect then target reaches Decode one edge later.
    apply(mk(0, 0, 0, 0, 0, 1, 32'h80,  IC, 32'h80, NOP, 32'h0,  0, 0), 102);
    apply(mk(0, 0, 0, 0, 0, 0, 32'h0,   ID, 32'h84, ID,  32'h88, 1, 0), 103);
    apply(mk(0, 0, 0, 0, 0, 0, 32'h0,   IE, 32'h88, IE,  32'h8C, 1, 1), 104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
